// File: rtl/fifo_wr_arbiter_if.sv
// Producer-side handshake bundle for fifo_wr_arbiter: per-producer valid/data in, one-hot ready out.
interface fifo_wr_arbiter_if #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned FIFO_WIDTH = 32
);
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*FIFO_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_ready;

  modport master (output req_valid, output req_data, input  req_ready);
  modport slave  (input  req_valid, input  req_data, output req_ready);
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing one FIFO write port; credit counter mirrors FIFO occupancy.
module fifo_wr_arbiter #(
  parameter  int unsigned NUM_REQ    = 4,
  parameter  int unsigned FIFO_WIDTH = 32,
  parameter  int unsigned FIFO_PTR   = 4,
  parameter  int unsigned FIFO_DEPTH = 16,
  parameter  int unsigned BURST_LEN  = 4,
  localparam int unsigned ID_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  fifo_wr_arbiter_if.slave      req,
  input  logic                  fifo_read_en,
  output logic                  fifo_write_en,
  output logic [FIFO_WIDTH-1:0] fifo_write_data,
  output logic [ID_W-1:0]       grant_id,
  output logic                  busy,
  output logic [FIFO_PTR:0]     credit,
  output logic                  err
);
  localparam int unsigned CNT_W  = $clog2(BURST_LEN + 1);
  localparam int unsigned CRED_W = FIFO_PTR + 1;

  typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_t;

  state_t            state, state_next;
  logic [ID_W-1:0]   last_grant, win_id, scan_id, acc_id;
  logic              win_found, credit_ok, owner_valid, accept, illegal_rd;
  logic [CNT_W-1:0]  beat_cnt;
  logic [CRED_W-1:0] credit_next;

  // First valid producer after last_grant, wrapping modulo NUM_REQ
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    scan_id   = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      scan_id = ID_W'((32'(last_grant) + k) % NUM_REQ);
      if (!win_found && req.req_valid[scan_id]) begin
        win_found = 1'b1;
        win_id    = scan_id;
      end
    end
  end

  always_comb begin
    credit_ok   = (credit != '0);
    owner_valid = req.req_valid[grant_id];
    acc_id      = (state == IDLE) ? win_id : grant_id;
    accept      = |(req.req_valid & req.req_ready);
    illegal_rd  = fifo_read_en && (credit == CRED_W'(FIFO_DEPTH));
    credit_next = illegal_rd ? CRED_W'(FIFO_DEPTH)
                             : credit - CRED_W'(accept) + CRED_W'(fifo_read_en);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:  if (accept && BURST_LEN > 1) state_next = BURST;
      BURST: begin
        if (accept) begin
          if (beat_cnt == CNT_W'(BURST_LEN - 1)) state_next = IDLE;
        end else if (!owner_valid) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Ready is combinational and gated by reset so nothing is accepted while rst is high
  always_comb begin
    req.req_ready = '0;
    if (!rst && credit_ok) begin
      case (state)
        IDLE:    if (win_found) req.req_ready[win_id] = 1'b1;
        BURST:   req.req_ready[grant_id] = 1'b1;
        default: req.req_ready = '0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fifo_write_en   <= 1'b0;
      fifo_write_data <= '0;
      grant_id        <= '0;
      last_grant      <= ID_W'(NUM_REQ - 1);
      beat_cnt        <= '0;
      busy            <= 1'b0;
      credit          <= CRED_W'(FIFO_DEPTH);
      err             <= 1'b0;
    end else begin
      fifo_write_en <= accept;
      busy          <= (state_next == BURST);
      credit        <= credit_next;
      if (illegal_rd) err <= 1'b1;
      if (accept) begin
        fifo_write_data <= req.req_data[32'(acc_id)*FIFO_WIDTH +: FIFO_WIDTH];
        if (state == IDLE) begin
          last_grant <= win_id;
          grant_id   <= win_id;
          beat_cnt   <= CNT_W'(1);
        end else begin
          beat_cnt   <= beat_cnt + CNT_W'(1);
        end
      end
    end
  end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter: directed scenarios plus random traffic against a rule-level model.
module tb_fifo_wr_arbiter;
  localparam int unsigned NR = 4, W = 32, PTR = 4, DEPTH = 16, BL = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           fifo_read_en = 1'b0;
  logic           fifo_write_en;
  logic [W-1:0]   fifo_write_data;
  logic [1:0]     grant_id;
  logic           busy;
  logic [PTR:0]   credit;
  logic           err;

  fifo_wr_arbiter_if #(.NUM_REQ(NR), .FIFO_WIDTH(W)) bus ();

  fifo_wr_arbiter #(
    .NUM_REQ(NR), .FIFO_WIDTH(W), .FIFO_PTR(PTR), .FIFO_DEPTH(DEPTH), .BURST_LEN(BL)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .req             (bus),
    .fifo_read_en    (fifo_read_en),
    .fifo_write_en   (fifo_write_en),
    .fifo_write_data (fifo_write_data),
    .grant_id        (grant_id),
    .busy            (busy),
    .credit          (credit),
    .err             (err)
  );

  always #5 clk = ~clk;

  int          tests = 0;
  int          fails = 0;
  logic [W-1:0] exp_q[$];
  int          wr_log[$];
  logic [W-1:0] dvec[NR];
  bit          hold_data = 1'b0;

  // Reference model: plain bookkeeping of the arbitration rules
  int m_credit, m_last, m_owner, m_beats, m_win;
  bit m_err, m_in_burst, m_prev_acc, m_acc;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_credit = DEPTH; m_last = NR - 1; m_owner = 0; m_beats = 0;
    m_err = 0; m_in_burst = 0; m_prev_acc = 0;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    bus.req_valid = '1;
    fifo_read_en  = 1'b0;
    #1;
    chk("rst_ready",    bus.req_ready, 0);
    chk("rst_write_en", fifo_write_en, 0);
    chk("rst_busy",     busy, 0);
    chk("rst_credit",   credit, DEPTH);
    chk("rst_grant",    grant_id, 0);
    chk("rst_err",      err, 0);
    exp_q.delete();
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    bus.req_valid = '0;
  endtask

  task automatic step(input logic [NR-1:0] v, input logic rd);
    logic [NR-1:0] exp_rdy;
    @(negedge clk);
    chk("write_en", fifo_write_en, m_prev_acc);
    chk("credit",   credit, m_credit);
    chk("err",      err, m_err);
    chk("busy",     busy, m_in_burst);
    chk("grant_id", grant_id, m_owner);
    bus.req_valid = v;
    fifo_read_en  = rd;
    for (int i = 0; i < NR; i++) begin
      if (!hold_data) dvec[i] = {8'(i), 24'($urandom)};
      bus.req_data[i*W +: W] = dvec[i];
    end
    exp_rdy = '0;
    m_win   = -1;
    if (m_credit != 0) begin
      if (m_in_burst) m_win = m_owner;
      else
        for (int k = 1; k <= NR; k++) begin
          if (m_win < 0 && v[(m_last + k) % NR]) m_win = (m_last + k) % NR;
        end
    end
    if (m_win >= 0) exp_rdy[m_win] = 1'b1;
    m_acc = (m_win >= 0) && v[m_win];
    if (m_acc) exp_q.push_back(dvec[m_win]);
    #1 chk("req_ready", bus.req_ready, exp_rdy);
    @(posedge clk);
    if (m_acc) begin
      if (!m_in_burst) begin
        m_last = m_win; m_owner = m_win; m_beats = 1; m_in_burst = (BL > 1);
      end else begin
        m_beats++;
      end
      if (m_beats == BL) m_in_burst = 0;
    end else if (m_in_burst && !v[m_owner]) begin
      m_in_burst = 0;
    end
    if (rd && m_credit == DEPTH) m_err = 1;
    else m_credit = m_credit - int'(m_acc) + int'(rd);
    m_prev_acc = m_acc;
  endtask

  // Monitor: every FIFO write pops the oldest expected beat
  initial forever begin
    @(negedge clk);
    if (fifo_write_en === 1'b1) begin
      wr_log.push_back(int'(fifo_write_data[31:24]));
      if (exp_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL sb_unexpected: got write %0h expected none at %0t", fifo_write_data, $time);
      end else begin
        chk("sb_data", fifo_write_data, exp_q.pop_front());
      end
    end
  end

  initial begin
    bus.req_valid = '0;
    bus.req_data  = '0;
    #2;
    do_reset();

    // All producers valid, no reads: four bursts of four, then credit exhausted
    wr_log.delete();
    repeat (18) step(4'hF, 1'b0);
    chk("order_cnt", wr_log.size(), 16);
    for (int i = 0; i < 16 && i < wr_log.size(); i++) chk("order", wr_log[i], i / 4);
    chk("credit_zero", credit, 0);

    // One read frees exactly one beat
    step(4'hF, 1'b1);
    #1 chk("credit_one", credit, 1);
    step(4'hF, 1'b0);
    #1 chk("credit_back_zero", credit, 0);
    step(4'hF, 1'b0);

    // Drain, then producer 1 drops mid-burst and producer 2 takes over
    repeat (16) step(4'h0, 1'b1);
    step(4'b0010, 1'b0);
    step(4'b0010, 1'b0);
    step(4'b0100, 1'b0);
    #1 chk("idle_after_drop", busy, 0);
    step(4'b0100, 1'b0);
    #1 chk("p2_granted", grant_id, 2);

    // Accept and read together at credit 5
    do_reset();
    repeat (11) step(4'b0001, 1'b0);
    #1 chk("credit_five", credit, 5);
    hold_data = 1'b1;
    for (int i = 0; i < NR; i++) dvec[i] = 32'hA5A5_A5A5;
    step(4'b0001, 1'b1);
    hold_data = 1'b0;
    #1 chk("credit_hold", credit, 5);
    chk("a5_data", fifo_write_data, 32'hA5A5_A5A5);
    step(4'b0000, 1'b0);

    // Read with a full credit pool is an error that sticks
    do_reset();
    step(4'b0000, 1'b1);
    #1 chk("err_set", err, 1);
    chk("err_credit", credit, DEPTH);
    repeat (3) step(4'b0000, 1'b0);
    #1 chk("err_sticky", err, 1);

    // Reset in the middle of producer 2's burst
    do_reset();
    step(4'b0100, 1'b0);
    step(4'b0100, 1'b0);
    #1 chk("mid_busy", busy, 1);
    chk("mid_grant", grant_id, 2);
    do_reset();
    step(4'hF, 1'b0);
    #1 chk("post_rst_winner", fifo_write_data[31:24], 0);

    // Random traffic
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      logic rd;
      rd = ($urandom_range(2) == 0);
      if (m_credit == DEPTH && $urandom_range(49) != 0) rd = 1'b0;
      step(4'($urandom), rd);
    end
    repeat (3) step(4'h0, 1'b0);
    chk("sb_leftover", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
